// File: rtl/mux_pkg.sv
// Shared constants and types for the 32:1 bit-slice multiplexer family.
package mux_pkg;
    localparam int MUX_SEL_W = 5;
    localparam int MUX_N_IN  = 32;

    typedef logic [MUX_N_IN-1:0] mux_in_t;
endpackage

// File: rtl/mux2_1.sv
// Gate-level 2:1 mux cell: y = (a & ~s) | (b & s).
module mux2_1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    logic s_n_s;
    logic a_term_s;
    logic b_term_s;

    not g_inv (s_n_s, s);
    and g_and_a (a_term_s, a, s_n_s);
    and g_and_b (b_term_s, b, s);
    or  g_or (y, a_term_s, b_term_s);
endmodule

// File: rtl/mux32to1_sel.sv
// 1-bit 32:1 mux built as a five-level balanced tree of mux2_1 cells,
// with an enable-gated registered copy of the result.
module mux32to1_sel
    import mux_pkg::*;
#(
    parameter int N_SEL = MUX_SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SEL-1:0] sel,
    input  mux_in_t          in,
    input  logic             en,
    output logic             out,
    output logic             out_q
);
    logic [15:0] lvl0_s;
    logic [7:0]  lvl1_s;
    logic [3:0]  lvl2_s;
    logic [1:0]  lvl3_s;
    logic        out_d;

    // Level 0 pairs adjacent inputs on the select LSB.
    for (genvar k = 0; k < 16; k++) begin : g_lvl0
        mux2_1 u_mux (.a(in[2*k]), .b(in[2*k+1]), .s(sel[0]), .y(lvl0_s[k]));
    end

    for (genvar k = 0; k < 8; k++) begin : g_lvl1
        mux2_1 u_mux (.a(lvl0_s[2*k]), .b(lvl0_s[2*k+1]), .s(sel[1]), .y(lvl1_s[k]));
    end

    for (genvar k = 0; k < 4; k++) begin : g_lvl2
        mux2_1 u_mux (.a(lvl1_s[2*k]), .b(lvl1_s[2*k+1]), .s(sel[2]), .y(lvl2_s[k]));
    end

    for (genvar k = 0; k < 2; k++) begin : g_lvl3
        mux2_1 u_mux (.a(lvl2_s[2*k]), .b(lvl2_s[2*k+1]), .s(sel[3]), .y(lvl3_s[k]));
    end

    mux2_1 u_lvl4 (.a(lvl3_s[0]), .b(lvl3_s[1]), .s(sel[4]), .y(out));

    // Next registered value: load the tree output when enabled, else hold.
    always_comb begin
        out_d = out_q;
        if (en) begin
            out_d = out;
        end else begin
            out_d = out_q;
        end
    end

    // Registered copy for pipelined read paths.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_mux32to1_sel.sv
// Self-checking bench for mux32to1_sel using a queue of expected values.
module tb_mux32to1_sel;
    import mux_pkg::*;

    logic         clk;
    logic         reset;
    logic [4:0]   sel;
    mux_in_t      in;
    logic         en;
    logic         out;
    logic         out_q;

    int checks;
    int errors;
    logic exp_q[$];
    logic exp_v;

    mux32to1_sel #(.N_SEL(5)) dut (
        .clk(clk), .reset(reset), .sel(sel), .in(in), .en(en),
        .out(out), .out_q(out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; sel = 5'd0; in = 32'hFFFF_FFFF;
        #1;
        exp_q.push_back(1'b0);
        exp_v = exp_q.pop_front();
        checks++;
        if (out_q !== exp_v) begin
            errors++;
            $display("FAIL reset_initial: out_q=%b required %b", out_q, exp_v);
        end
        exp_q.push_back(1'b0);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out_q !== exp_v) begin
            errors++;
            $display("FAIL reset_hold_edge: out_q=%b required %b", out_q, exp_v);
        end
    endtask

    task automatic test_onehot();
        for (int i = 0; i < 32; i++) begin
            for (int s = 0; s < 32; s++) begin
                @(negedge clk);
                in = 32'h0000_0001 << i;
                sel = 5'(s);
                exp_q.push_back((s == i) ? 1'b1 : 1'b0);
                #1;
                exp_v = exp_q.pop_front();
                checks++;
                if (out !== exp_v) begin
                    errors++;
                    $display("FAIL onehot i=%0d sel=%0d: out=%b required %b", i, s, out, exp_v);
                end
            end
        end
    endtask

    task automatic test_pattern();
        in = 32'hAAAA_5555;
        for (int s = 0; s < 32; s++) begin
            sel = 5'(s);
            if (s < 16) exp_q.push_back((s % 2 == 0) ? 1'b1 : 1'b0);
            else        exp_q.push_back((s % 2 == 0) ? 1'b0 : 1'b1);
            #10;
            exp_v = exp_q.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL pattern sel=%0d: out=%b required %b", s, out, exp_v);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [4:0] bsel [4];
        logic       bexp [4];
        bsel[0] = 5'd0;  bexp[0] = 1'b1;
        bsel[1] = 5'd31; bexp[1] = 1'b1;
        bsel[2] = 5'd1;  bexp[2] = 1'b0;
        bsel[3] = 5'd30; bexp[3] = 1'b0;
        in = 32'h8000_0001;
        for (int k = 0; k < 4; k++) begin
            sel = bsel[k];
            exp_q.push_back(bexp[k]);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL boundary sel=%0d: out=%b required %b", bsel[k], out, exp_v);
            end
        end
        for (int v = 0; v < 2; v++) begin
            in = (v == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
            for (int s = 0; s < 32; s++) begin
                sel = 5'(s);
                exp_q.push_back((v == 0) ? 1'b0 : 1'b1);
                #1;
                exp_v = exp_q.pop_front();
                checks++;
                if (out !== exp_v) begin
                    errors++;
                    $display("FAIL uniform in=%h sel=%0d: out=%b required %b", in, s, out, exp_v);
                end
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        reset = 1'b1; in = 32'h0000_0004; sel = 5'd2; en = 1'b1;
        #1;
        exp_q.push_back(1'b0);
        exp_v = exp_q.pop_front();
        checks++;
        if (out_q !== exp_v) begin
            errors++;
            $display("FAIL reg_reset: out_q=%b required %b", out_q, exp_v);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(1'b1);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out_q !== exp_v) begin
            errors++;
            $display("FAIL reg_load: out_q=%b required %b", out_q, exp_v);
        end
        @(negedge clk);
        en = 1'b0; sel = 5'd3;
        exp_q.push_back(1'b0);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL reg_comb_sel3: out=%b required %b", out, exp_v);
        end
        exp_q.push_back(1'b1);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out_q !== exp_v) begin
            errors++;
            $display("FAIL reg_hold: out_q=%b required %b", out_q, exp_v);
        end
        @(negedge clk);
        en = 1'b1;
        exp_q.push_back(1'b0);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out_q !== exp_v) begin
            errors++;
            $display("FAIL reg_reload: out_q=%b required %b", out_q, exp_v);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in = 32'h0000_0004; sel = 5'd2; en = 1'b1;
        exp_q.push_back(1'b1);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out_q !== exp_v) begin
            errors++;
            $display("FAIL async_preload: out_q=%b required %b", out_q, exp_v);
        end
        @(negedge clk); #1;
        reset = 1'b1;
        exp_q.push_back(1'b0);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out_q !== exp_v) begin
            errors++;
            $display("FAIL async_clear: out_q=%b required %b", out_q, exp_v);
        end
        exp_q.push_back(1'b1);
        exp_v = exp_q.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL async_comb: out=%b required %b", out, exp_v);
        end
        exp_q.push_back(1'b0);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out_q !== exp_v) begin
            errors++;
            $display("FAIL async_hold: out_q=%b required %b", out_q, exp_v);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_unselected_x();
        in = {31'bx, 1'b1};
        sel = 5'd0;
        exp_q.push_back(1'b1);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL unselected_x: out=%b required %b", out, exp_v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        reset = 1'b0;
        test_onehot();
        test_pattern();
        test_boundaries();
        test_registered();
        test_async_reset();
        test_unselected_x();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
